// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one external ALU between two requesters,
// one operation in flight, with a registered result and condition-code register.
module alu_arb #(
    parameter int DATA_WID = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [1:0]          req0_fun,
    input  logic [DATA_WID-1:0] req0_a,
    input  logic [DATA_WID-1:0] req0_b,
    input  logic                req0_setcc,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [1:0]          req1_fun,
    input  logic [DATA_WID-1:0] req1_a,
    input  logic [DATA_WID-1:0] req1_b,
    input  logic                req1_setcc,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [DATA_WID-1:0] rsp_valE,
    output logic [1:0]          ALUfun,
    output logic [DATA_WID-1:0] ALUA,
    output logic [DATA_WID-1:0] ALUB,
    input  logic [DATA_WID-1:0] valE,
    input  logic [3:0]          CC,
    output logic [3:0]          cc_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t              state_q, state_d;
    logic                prio_q, prio_d, owner_q, owner_d, setcc_q, setcc_d;
    logic [1:0]          fun_q, fun_d;
    logic [DATA_WID-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]          cc_q, cc_d;
    logic                gnt0, gnt1, acc, rsp_hs;
    // prio only breaks ties; a lone valid requester always wins
    assign gnt0       = req0_valid & (~req1_valid | ~prio_q);
    assign gnt1       = req1_valid & (~req0_valid | prio_q);
    assign req0_ready = ~rst & (state_q == IDLE) & gnt0;
    assign req1_ready = ~rst & (state_q == IDLE) & gnt1;
    assign rsp0_valid = ~rst & (state_q == RESP) & ~owner_q;
    assign rsp1_valid = ~rst & (state_q == RESP) & owner_q;
    assign acc        = req0_ready | req1_ready;
    assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
    assign ALUfun     = fun_q;
    assign ALUA       = a_q;
    assign ALUB       = b_q;
    assign rsp_valE   = res_q;
    assign cc_out     = cc_q;
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        setcc_d = setcc_q;
        fun_d   = fun_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE: if (acc) begin
                state_d = ISSUE;
                owner_d = req1_ready;
                prio_d  = ~req1_ready;
                fun_d   = req1_ready ? req1_fun   : req0_fun;
                a_d     = req1_ready ? req1_a     : req0_a;
                b_d     = req1_ready ? req1_b     : req0_b;
                setcc_d = req1_ready ? req1_setcc : req0_setcc;
            end
            ISSUE: begin
                state_d = RESP;
                res_d   = valE;
                cc_d    = setcc_q ? CC : cc_q;
            end
            RESP: state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            setcc_q <= 1'b0;
            fun_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            setcc_q <= setcc_d;
            fun_q   <= fun_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cc_q    <= cc_d;
        end
    end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: randomized scoreboard bench for alu_arb; the bench plays the external ALU.
module tb_alu_arb;
    localparam int W = 64;
    logic         clk = 1'b0, rst = 1'b1;
    logic         req0_valid, req0_ready, req0_setcc, req1_valid, req1_ready, req1_setcc;
    logic [1:0]   req0_fun, req1_fun, ALUfun;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_valE, ALUA, ALUB, valE;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [3:0]   CC, cc_out;
    alu_arb #(.DATA_WID(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
        .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
        .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_valE(rsp_valE), .ALUfun(ALUfun), .ALUA(ALUA), .ALUB(ALUB),
        .valE(valE), .CC(CC), .cc_out(cc_out)
    );
    always #5 clk = ~clk;
    function automatic logic [W-1:0] alu_f(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        return f == 2'd0 ? a + b : f == 2'd1 ? a - b : f == 2'd2 ? a & b : a ^ b;
    endfunction
    function automatic logic [3:0] alu_cc(input logic [W-1:0] r);
        return {r == '0, r[W-1], r[3], r[0]};
    endfunction
    assign valE = alu_f(ALUfun, ALUA, ALUB);
    assign CC   = alu_cc(valE);
    typedef struct packed {
        logic         owner;
        logic [W-1:0] res;
        logic [3:0]   cc;
    } exp_t;
    exp_t sb[$];
    int   n_pass = 0, n_tot = 0;
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask
    // grant/busy model: tracks the arbitration outcome and occupancy from the rules alone
    logic       busy = 1'b0, own = 1'b0, prio_m = 1'b0;
    logic [3:0] cc_m = '0;
    int         k = 0;
    always @(negedge clk) begin
        logic gv, g;
        logic [W-1:0] r;
        if (rst) begin
            chk("rst_hs", {60'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, '0);
            chk("rst_valE", rsp_valE, '0);
            chk("rst_cc", {60'd0, cc_out}, '0);
            sb.delete();
            busy = 1'b0; prio_m = 1'b0; cc_m = '0;
        end else if (!busy) begin
            gv = req0_valid | req1_valid;
            g  = (req0_valid && req1_valid) ? prio_m : req1_valid;
            chk("grant", {62'd0, req1_ready, req0_ready}, gv ? (64'd1 << g) : 64'd0);
            chk("rsp_idle", {62'd0, rsp1_valid, rsp0_valid}, '0);
            if (gv) begin
                r = g ? alu_f(req1_fun, req1_a, req1_b) : alu_f(req0_fun, req0_a, req0_b);
                if (g ? req1_setcc : req0_setcc) cc_m = alu_cc(r);
                sb.push_back('{owner: g, res: r, cc: cc_m});
                busy = 1'b1; own = g; prio_m = ~g; k = 0;
            end
        end else begin
            k++;
            chk("rdy_busy", {62'd0, req1_ready, req0_ready}, '0);
            chk("rsp_vld", {62'd0, rsp1_valid, rsp0_valid}, k >= 2 ? (64'd1 << own) : 64'd0);
            if (k >= 2 && (own ? rsp1_ready : rsp0_ready)) busy = 1'b0;
        end
    end
    // response monitor: every cycle a response is presented it must match the queue head
    always @(negedge clk) begin
        if (!rst && (rsp0_valid || rsp1_valid)) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL sb_empty: got response with no expected entry at %0t", $time);
            end else begin
                chk("rsp_owner", {63'd0, rsp1_valid}, {63'd0, sb[0].owner});
                chk("rsp_valE", rsp_valE, sb[0].res);
                chk("cc_out", {60'd0, cc_out}, {60'd0, sb[0].cc});
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) void'(sb.pop_front());
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic rnd_ops();
        req0_fun = 2'($urandom); req1_fun = 2'($urandom);
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        req0_setcc = 1'($urandom); req1_setcc = 1'($urandom);
    endtask
    initial begin
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_fun = 0; req1_fun = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_setcc = 0; req1_setcc = 0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        // single add 5+3 with setcc
        req0_valid = 1; req0_fun = 2'd0; req0_a = 5; req0_b = 3; req0_setcc = 1; rsp0_ready = 1;
        cyc();
        req0_valid = 0;
        repeat (4) cyc();
        // no-setcc op must leave cc_out alone
        req1_valid = 1; req1_fun = 2'd1; req1_a = 0; req1_b = 1; req1_setcc = 0; rsp1_ready = 1;
        cyc();
        req1_valid = 0;
        repeat (4) cyc();
        // both valid continuously: grants alternate
        req0_valid = 1; req1_valid = 1;
        repeat (24) begin rnd_ops(); cyc(); end
        // owner 0 stalls while the other channel's ready is high
        rsp0_ready = 0; rsp1_ready = 1;
        repeat (10) cyc();
        rsp0_ready = 1;
        repeat (10) cyc();
        // random traffic
        repeat (300) begin
            rnd_ops();
            req0_valid = ($urandom_range(0, 9) < 6); req1_valid = ($urandom_range(0, 9) < 6);
            rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
            cyc();
        end
        // asynchronous reset during ISSUE
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) break;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_alu", {ALUfun, 62'd0} | ALUA | ALUB, '0);
        chk("arst_valE", rsp_valE, '0);
        chk("arst_cc", {60'd0, cc_out}, '0);
        chk("arst_hs", {60'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (20) begin rnd_ops(); cyc(); end
        repeat (150) begin
            rnd_ops();
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
            cyc();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (6) cyc();
        n_tot++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
